// File: rtl/frame_strobe_writer_if.sv
// Bundles the stream input and the FrameData/FrameStrobe bus of one fabric column.
//   s_data/s_valid/s_ready : 32-bit configuration word stream (valid/ready handshake)
//   FrameData              : NumRows rows of FrameBitsPerRow bits, row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe            : one-hot frame write strobe (all zero when idle)
//   busy/done/err          : writer status (done/err are single-cycle pulses)
// Modports: master = stream source / status observer, slave = the frame writer.
interface frame_strobe_writer_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4
);
  logic [FrameBitsPerRow-1:0]         s_data;
  logic                               s_valid;
  logic                               s_ready;
  logic [NumRows*FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0]         FrameStrobe;
  logic                               busy;
  logic                               done;
  logic                               err;

  modport master (output s_data, s_valid,
                  input  s_ready, FrameData, FrameStrobe, busy, done, err);
  modport slave  (input  s_data, s_valid,
                  output s_ready, FrameData, FrameStrobe, busy, done, err);
endinterface

// File: rtl/frame_strobe_writer.sv
// Frame writer for one fabric column. Takes a header word (sync 8'hA5, frame count-1 in [12:8],
// start frame in [4:0]), then NumRows data words per frame, drives the assembled frame on FrameData
// and pulses the frame's FrameStrobe bit for StrobeWidth cycles with one idle cycle of setup before
// and hold after. Bursts running past the last frame of the column abort with err.
// Ports:
//   UserCLK : clock
//   Reset   : asynchronous, active-high
//   bus     : frame_strobe_writer_if.slave (stream in, FrameData/FrameStrobe/busy/done/err out)
// Optional feature: define FRAME_WRITER_CHECKSUM_EN to require a trailer word after the last frame,
// equal to the XOR of all burst data words; match -> done, mismatch -> err.

// One FrameData row register.
module frame_row_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (we) q <= d;
endmodule

module frame_strobe_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4,
  parameter int StrobeWidth     = 2
) (
  input logic                  UserCLK,
  input logic                  Reset,
  frame_strobe_writer_if.slave bus
);
  localparam int W   = FrameBitsPerRow;
  localparam int RW  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SCW = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, STROBE, HOLD
`ifdef FRAME_WRITER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t                     state_q, state_d;
  logic [4:0]                 idx_q, idx_d;
  logic [4:0]                 rem_q, rem_d;
  logic [RW-1:0]              row_q, row_d;
  logic [SCW-1:0]             scnt_q, scnt_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d, strobe_sel;
  logic                       busy_q, done_q, err_q, done_d, err_d;
  logic [NumRows-1:0][W-1:0]  rows;
  logic [NumRows-1:0]         row_we;
  logic                       accept, load_acc;
  logic                       hdr_ok;
  logic [4:0]                 hdr_f, hdr_n;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [W-1:0]               csum_q, csum_d;
`endif

`ifdef FRAME_WRITER_CHECKSUM_EN
  assign bus.s_ready = (state_q == IDLE) | (state_q == LOAD) | (state_q == CHECK);
`else
  assign bus.s_ready = (state_q == IDLE) | (state_q == LOAD);
`endif
  assign accept   = bus.s_valid & bus.s_ready;
  assign load_acc = accept & (state_q == LOAD);
  assign hdr_ok   = (bus.s_data[31:24] == 8'hA5);
  assign hdr_n    = bus.s_data[12:8];
  assign hdr_f    = bus.s_data[4:0];

  // Row storage: packed layout puts row k at bits [k*W +: W], which is exactly the FrameData layout.
  for (genvar k = 0; k < NumRows; k++) begin : g_row
    assign row_we[k] = load_acc & (32'(row_q) == k);
    frame_row_reg #(.W(W)) u_row (
      .clk(UserCLK), .rst(Reset), .we(row_we[k]), .d(bus.s_data), .q(rows[k])
    );
  end
  assign bus.FrameData   = rows;
  assign bus.FrameStrobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

  // Decoded strobe bit for the current frame; idx is always in range once a header is accepted.
  always_comb begin
    strobe_sel = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) strobe_sel[i] = (32'(idx_q) == i);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    row_d    = row_q;
    scnt_d   = scnt_q;
    strobe_d = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef FRAME_WRITER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        if (!hdr_ok || 32'(hdr_f) >= MaxFramesPerCol) err_d = 1'b1;
        else begin
          idx_d   = hdr_f;
          rem_d   = hdr_n;
          row_d   = '0;
          state_d = LOAD;
`ifdef FRAME_WRITER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: if (accept) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
        csum_d = csum_q ^ bus.s_data;
`endif
        if (32'(row_q) == NumRows - 1) begin
          row_d   = '0;
          state_d = SETUP;
        end else row_d = row_q + 1'b1;
      end
      SETUP: begin
        strobe_d = strobe_sel;
        scnt_d   = '0;
        state_d  = STROBE;
      end
      STROBE: begin
        if (32'(scnt_q) == StrobeWidth - 1) state_d = HOLD;
        else begin
          strobe_d = strobe_q;
          scnt_d   = scnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (rem_q == '0) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
          state_d = CHECK;
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else if (32'(idx_q) + 1 >= MaxFramesPerCol) begin
          // Burst would run off the column: abort, frames already written stay.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 5'd1;
          rem_d   = rem_q - 5'd1;
          state_d = LOAD;
        end
      end
`ifdef FRAME_WRITER_CHECKSUM_EN
      CHECK: if (accept) begin
        if (bus.s_data == csum_q) done_d = 1'b1;
        else                      err_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      row_q    <= '0;
      scnt_q   <= '0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FRAME_WRITER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      row_q    <= row_d;
      scnt_q   <= scnt_d;
      strobe_q <= strobe_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef FRAME_WRITER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_frame_strobe_writer.sv
module tb_frame_strobe_writer;
  localparam int W  = 32;
  localparam int MF = 20;
  localparam int NR = 4;
  localparam int SW = 2;
  localparam int FW = NR * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_strobe_writer_if #(.FrameBitsPerRow(W), .MaxFramesPerCol(MF), .NumRows(NR)) bus();
  frame_strobe_writer #(.FrameBitsPerRow(W), .MaxFramesPerCol(MF), .NumRows(NR), .StrobeWidth(SW))
    dut (.UserCLK(clk), .Reset(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // Passive event log, sampled on the falling edge.
  int          cyc = 0;
  int          rise_idx[$];
  logic [FW-1:0] rise_data[$];
  int          rise_cyc[$];
  int          run_len[$];
  int          done_cyc[$];
  int          err_cyc[$];
  int          acc_cyc[$];
  int          bad_strobe = 0;
  int          cur_run = 0;
  logic [MF-1:0] prev_strobe = '0;

  function automatic int first_set(input logic [MF-1:0] v);
    for (int i = 0; i < MF; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.FrameStrobe != '0) begin
      if ($countones(bus.FrameStrobe) != 1 || !bus.busy) bad_strobe++;
      if (prev_strobe == '0) begin
        rise_idx.push_back(first_set(bus.FrameStrobe));
        rise_data.push_back(bus.FrameData);
        rise_cyc.push_back(cyc);
        cur_run = 0;
      end else if (bus.FrameStrobe != prev_strobe) bad_strobe++;
      cur_run++;
    end else if (prev_strobe != '0) run_len.push_back(cur_run);
    if (bus.done) done_cyc.push_back(cyc);
    if (bus.err)  err_cyc.push_back(cyc);
    if (bus.s_valid && bus.s_ready) acc_cyc.push_back(cyc);
    prev_strobe = bus.FrameStrobe;
  end

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] w, input int gap);
    int t;
    logic acc;
    repeat (gap) @(posedge clk);
    #1;
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.s_valid = 1'b0;
    chk("send_accept", FW'(acc), FW'(1));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", FW'(bus.busy), FW'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] hdr(input int f, input int n);
    logic [4:0] ff, nn;
    ff = 5'(f);
    nn = 5'(n);
    return {8'hA5, 11'h0, nn, 3'b000, ff};
  endfunction

  int burst_acc_base;

  // Reference: frames written = min(N+1, MaxFrames-F); done only when the whole burst fits
  // (and, with the trailer feature, the trailer equals the XOR of all data words).
  // mode: 0 random words, 1 words 1,2,3..., 2 words 1,2,4,8...
  task automatic run_burst(input int f, input int n, input int mode, input bit gaps, input bit bad_trl);
    int nfr, b_r, b_l, b_d, b_e;
    bit fits, exp_done;
    logic [W-1:0] words[$];
    logic [W-1:0] x, wv;
    logic [FW-1:0] fr;
    fits = (f < MF) && (n + 1 <= MF - f);
    nfr  = (f >= MF) ? 0 : (fits ? n + 1 : MF - f);
    x = '0;
    for (int i = 0; i < nfr * NR; i++) begin
      wv = (mode == 1) ? W'(i + 1) : (mode == 2) ? (W'(1) << i) : W'($urandom);
      words.push_back(wv);
      x ^= wv;
    end
    b_r = rise_idx.size(); b_l = run_len.size(); b_d = done_cyc.size(); b_e = err_cyc.size();
    burst_acc_base = acc_cyc.size();
    send(hdr(f, n), 0);
    foreach (words[i]) send(words[i], gaps ? $urandom_range(0, 2) : 0);
    exp_done = fits;
`ifdef FRAME_WRITER_CHECKSUM_EN
    if (fits) send(bad_trl ? (x ^ W'(1)) : x, 0);
    exp_done = fits && !bad_trl;
`endif
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("frames_written", FW'(rise_idx.size() - b_r), FW'(nfr));
    for (int j = 0; j < nfr && b_r + j < rise_idx.size(); j++) begin
      for (int k = 0; k < NR; k++) fr[k*W +: W] = words[j*NR + k];
      chk("strobe_index", FW'(rise_idx[b_r + j]), FW'(f + j));
      chk("frame_data",   rise_data[b_r + j], fr);
      if (b_l + j < run_len.size()) chk("strobe_width", FW'(run_len[b_l + j]), FW'(SW));
      if (j == nfr - 1) chk("data_kept", bus.FrameData, fr);
    end
    chk("done_count", FW'(done_cyc.size() - b_d), FW'(exp_done));
    chk("err_count",  FW'(err_cyc.size() - b_e),  FW'(!exp_done));
    if (bad_trl) ; // trailer flag only matters with the checksum build
  endtask

  initial begin
    int b_r, b_d, b_e, t, f, n;
    logic [W-1:0] x;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  FW'(bus.s_ready), FW'(1));
    chk("rst_strobe", FW'(bus.FrameStrobe), FW'(0));
    chk("rst_data",   bus.FrameData, FW'(0));
    chk("rst_busy",   FW'(bus.busy), FW'(0));
    chk("rst_done",   FW'(bus.done), FW'(0));
    chk("rst_err",    FW'(bus.err), FW'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single frame at F=3, words 1..4, with latency check
    run_burst(3, 0, 1, 1'b0, 1'b0);
    chk("t1_data", bus.FrameData, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t1_strobe_lat", FW'(rise_cyc[rise_cyc.size()-1]), FW'(acc_cyc[burst_acc_base + NR] + 2));
`ifndef FRAME_WRITER_CHECKSUM_EN
    chk("t1_done_lat", FW'(done_cyc[done_cyc.size()-1]), FW'(acc_cyc[burst_acc_base + NR] + 3 + SW));
`endif

    // Burst overflowing the column: F=18, N=2
    run_burst(18, 2, 0, 1'b0, 1'b0);

    // Bad sync word in IDLE, then out-of-range start frame
    b_r = rise_idx.size(); b_e = err_cyc.size();
    send(32'h1234_5678, 0);
    @(negedge clk);
    chk("t3_ready",     FW'(bus.s_ready), FW'(1));
    chk("t3_strobe",    FW'(bus.FrameStrobe), FW'(0));
    wait_idle();
    chk("t3_err",       FW'(err_cyc.size() - b_e), FW'(1));
    chk("t3_no_strobe", FW'(rise_idx.size() - b_r), FW'(0));
    run_burst(20, 0, 0, 1'b0, 1'b0);

    // Stall between words 2 and 3 of a two-frame burst
    b_r = rise_idx.size(); b_d = done_cyc.size();
    x = '0;
    send(hdr(0, 1), 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("t4_no_early_strobe", FW'(rise_idx.size() - b_r), FW'(1));
      send(W'(i), (i == 3) ? 5 : 0);
      x ^= W'(i);
    end
`ifdef FRAME_WRITER_CHECKSUM_EN
    send(x, 0);
`endif
    wait_idle();
    chk("t4_frames", FW'(rise_idx.size() - b_r), FW'(2));
    if (rise_idx.size() - b_r == 2) begin
      chk("t4_idx0", FW'(rise_idx[b_r]), FW'(0));
      chk("t4_idx1", FW'(rise_idx[b_r + 1]), FW'(1));
      chk("t4_data1", rise_data[b_r], {32'd4, 32'd3, 32'd2, 32'd1});
    end
    chk("t4_done", FW'(done_cyc.size() - b_d), FW'(1));

    // Reset asserted while the strobe is high
    b_d = done_cyc.size(); b_e = err_cyc.size();
    send(hdr(7, 0), 0);
    for (int i = 0; i < NR; i++) send(W'($urandom), 0);
    t = 0;
    @(negedge clk);
    while (bus.FrameStrobe == '0 && t < 50) begin @(negedge clk); t++; end
    chk("t5_strobe_seen", FW'(bus.FrameStrobe), FW'(20'h00080));
    #1 rst = 1'b1;
    #1;
    chk("t5_strobe_drop", FW'(bus.FrameStrobe), FW'(0));
    chk("t5_busy_drop",   FW'(bus.busy), FW'(0));
    chk("t5_data_clear",  bus.FrameData, FW'(0));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("t5_no_done", FW'(done_cyc.size() - b_d), FW'(0));
    chk("t5_no_err",  FW'(err_cyc.size() - b_e), FW'(0));
    run_burst(2, 1, 0, 1'b0, 1'b0);

`ifdef FRAME_WRITER_CHECKSUM_EN
    // Trailer check: words 1,2,4,8 -> XOR 0x0F good, 0x0E bad
    run_burst(5, 0, 2, 1'b0, 1'b0);
    run_burst(5, 0, 2, 1'b0, 1'b1);
`endif

    // Randomized bursts against the reference
    for (int r = 0; r < 24; r++) begin
      if (r % 4 == 3) begin f = $urandom_range(15, 19); n = $urandom_range(2, 6); end
      else if (r % 7 == 5) begin f = $urandom_range(20, 31); n = $urandom_range(0, 3); end
      else begin f = $urandom_range(0, 19); n = $urandom_range(0, 3); end
      run_burst(f, n, 0, 1'b1, bit'($urandom_range(0, 1)));
    end

    chk("strobe_onehot", FW'(bad_strobe), FW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
